// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types and byte constants for the PS/2 scancode sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXT    = 3'd1,
        BRK    = 3'd2,
        EXTBRK = 3'd3,
        SKIP   = 3'd4
    } ps2_dec_state_t;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_OVR0     = 8'h00;
    localparam logic [7:0] PS2_OVR1     = 8'hFF;

    // 'release' is a reserved word, so the break flag is called 'released'.
    typedef struct packed {
        logic       released;
        logic       ext;
        logic [7:0] code;
    } ps2_key_evt_t;

    // Keyboard housekeeping bytes that carry no key information.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

    // Keyboard-reported error / buffer-overrun bytes.
    function automatic logic is_error_byte(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1) || (b == PS2_BAT_FAIL);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_evt_fifo.sv
// First-word fall-through FIFO of decoded key events.
// Pointers carry one extra wrap bit; full = wrap bits differ, index bits equal.
// A write into a full FIFO succeeds when a read happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clkin,
    input  logic         rst_n,
    input  logic         wr_en,
    input  ps2_key_evt_t wr_data,
    output logic         full,
    input  logic         rd_en,
    output ps2_key_evt_t rd_data,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    ps2_key_evt_t mem [DEPTH];
    logic         do_rd;
    logic         do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted operations.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode-set-2 sequencer: turns the PHY byte stream into key events
// and queues them for the CPU side.
// Optional feature: define PS2_PREFIX_TIMEOUT_EN to abandon a pending prefix
// or pause skip after TIMEOUT_CYCLES idle clocks.
//
// Handshakes: a transfer happens on a clock edge where valid & ready are both
// 1; the sender holds data stable while valid is high and ready is low.
// sym_ready is 1 every cycle after reset; key_valid means FIFO non-empty and
// key_valid & key_ready pops the head.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic [7:0] sym_data,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    output logic       proto_err
);

    // The decoder state is kept in a named enum so checkers can bind to it.
    ps2_dec_state_t state, state_d;
    logic [2:0]     skip_cnt, skip_d;
    logic [7:0]     byte_q;
    logic           byte_vld;
    logic           push;
    ps2_key_evt_t   push_evt;
    logic           err_d;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           timeout_hit;
    ps2_key_evt_t   head;

`ifdef PS2_PREFIX_TIMEOUT_EN
    logic [23:0] idle_cnt;

    // A byte in the same cycle wins over the timeout.
    assign timeout_hit = (state != IDLE) && !byte_vld && (idle_cnt == 24'(TIMEOUT_CYCLES));

    // Idle counter: cleared by bytes and by the timeout, counts while a prefix is pending.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)                      idle_cnt <= '0;
        else if (byte_vld || timeout_hit) idle_cnt <= '0;
        else if (state != IDLE)          idle_cnt <= idle_cnt + 24'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Ready register and one-stage input capture of the accepted byte.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sym_ready <= 1'b0;
            byte_vld  <= 1'b0;
            byte_q    <= '0;
        end else begin
            sym_ready <= 1'b1;
            byte_vld  <= sym_valid & sym_ready;
            if (sym_valid & sym_ready) byte_q <= sym_data;
        end
    end

    // Decode next state, skip count, event push and error for the captured byte.
    always_comb begin
        state_d  = state;
        skip_d   = skip_cnt;
        push     = 1'b0;
        push_evt = '0;
        err_d    = 1'b0;
        if (byte_vld) begin
            if (state == SKIP) begin
                skip_d = 3'(skip_cnt - 3'd1);
                if (skip_cnt <= 3'd1) begin
                    state_d = IDLE;
                    skip_d  = '0;
                end
            end else if (byte_q == PS2_EXT) begin
                err_d   = (state != IDLE);
                state_d = EXT;
            end else if (byte_q == PS2_BRK) begin
                if (state == BRK || state == EXTBRK) err_d = 1'b1;
                else if (state == EXT)               state_d = EXTBRK;
                else                                 state_d = BRK;
            end else if (byte_q == PS2_PAUSE) begin
                push     = 1'b1;
                push_evt = '{released: 1'b0, ext: 1'b0, code: PS2_PAUSE};
                skip_d   = 3'd7;
                state_d  = SKIP;
            end else if (is_status_byte(byte_q)) begin
                state_d = IDLE;
            end else if (is_error_byte(byte_q)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                push     = 1'b1;
                push_evt = '{released: (state == BRK || state == EXTBRK),
                             ext:      (state == EXT || state == EXTBRK),
                             code:     byte_q};
                state_d  = IDLE;
            end
        end else if (timeout_hit) begin
            state_d = IDLE;
            skip_d  = '0;
            err_d   = 1'b1;
        end
    end

    // Decoder state, skip counter and registered status pulses.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_d;
            skip_cnt  <= skip_d;
            overflow  <= push & fifo_full & ~pop;
            proto_err <= err_d;
        end
    end

    assign pop = key_valid & key_ready;

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_data(push_evt),
        .full   (fifo_full),
        .rd_en  (pop),
        .rd_data(head),
        .empty  (fifo_empty)
    );

    assign key_valid   = ~fifo_empty;
    assign key_code    = head.code;
    assign key_release = head.released;
    assign key_ext     = head.ext;

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

- Sequences the raw PS/2 scancode byte stream from the PS/2 physical receiver into complete key events.
- Decodes the scan-code set 2 prefixes `E0` (extended), `F0` (break) and `E1` (pause), and discards keyboard status bytes.
- Buffers the decoded events in a small FIFO for the CPU-side consumer.
- Sits directly downstream of the PHY's 8-bit valid/ready symbol bus and upstream of the keyboard MMIO/interrupt logic.

## Interface
Parameters:
- `FIFO_DEPTH`, 8 — event FIFO entries; power of two, minimum 2.
- `TIMEOUT_CYCLES`, 2500000 — idle `clkin` cycles before a pending prefix is abandoned. Used only with `PS2_PREFIX_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clkin` in 1 — system clock; the only clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `sym_data` in 8 — scancode byte from the PHY.
- `sym_valid` in 1 — byte available.
- `sym_ready` out 1 — byte accepted.
- `key_code` out 8 — event scancode, FIFO head.
- `key_release` out 1 — 1 = break (key up), 0 = make.
- `key_ext` out 1 — event was `E0`-prefixed.
- `key_valid` out 1 — FIFO non-empty.
- `key_ready` in 1 — consumer pops the head.
- `overflow` out 1 — one-cycle pulse: an event was dropped because the FIFO was full.
- `proto_err` out 1 — one-cycle pulse: protocol error or keyboard error byte.

## Operation
- **Byte acceptance:** a byte is accepted when `sym_valid & sym_ready`. `sym_ready` is registered: 0 in reset, 1 from the first clock after reset and every cycle thereafter. The block never back-pressures the PHY.

Decode state machine, states `IDLE`, `EXT`, `BRK`, `EXTBRK`, `SKIP`. Transitions on an accepted byte:
- `E0`:
  - `IDLE` -> `EXT`.
  - `BRK` or `EXTBRK` -> `EXT`, with a `proto_err` pulse.
  - `EXT` stays in `EXT`, with a `proto_err` pulse.
- `F0`:
  - `IDLE` -> `BRK`.
  - `EXT` -> `EXTBRK`.
  - `BRK` or `EXTBRK` stays put, with a `proto_err` pulse.
- `E1` from any state:
  - Push event {code=`E1`, release=0, ext=0}.
  - Load the 3-bit skip counter with 7 and go to `SKIP`.
- `SKIP`:
  - Every accepted byte, whatever its value, decrements the skip counter.
  - Reaching 0 -> `IDLE`.
  - No events are produced while in `SKIP`.
- Status bytes `AA`, `FA`, `EE`, `FE`: discarded; state -> `IDLE`.
- Error bytes `00`, `FF`, `FC`: discarded; `proto_err` pulse; state -> `IDLE`.
- Any other byte:
  - Push event {code=byte, release=(state is `BRK` or `EXTBRK`), ext=(state is `EXT` or `EXTBRK`)}.
  - State -> `IDLE`.
- **FIFO full on push:** the event is dropped, `overflow` pulses, and the state transition still occurs.
- **Reset mid-sequence:** state -> `IDLE`, skip counter 0, FIFO emptied, pulses 0.

## Timing
- **Reset values:** `sym_ready`=0, `key_valid`=0, `key_code`=0, `key_release`=0, `key_ext`=0, `overflow`=0, `proto_err`=0.
- **Latency:** byte accepted at edge N -> event visible at FIFO head with `key_valid`=1 after edge N+1 when the FIFO was empty. There is no combinational bypass.
- **FIFO read side:** first-word fall-through. A pop occurs on `key_valid & key_ready`; the next entry (or `key_valid`=0) appears after that edge.
- **Simultaneous push and pop:**
  - FIFO full: the push succeeds and no overflow is signalled.
  - FIFO empty: only the push takes effect.
- **Pointers:** `log2(FIFO_DEPTH)+1` bits wide, wrap modulo 2·`FIFO_DEPTH`. Full = MSBs differ and the rest are equal.
- **Pulse timing:** `overflow` and `proto_err` are registered and assert the cycle after the offending byte.

## Configuration
- **`PS2_PREFIX_TIMEOUT_EN` defined:**
  - A 24-bit idle counter clears on every accepted byte and on reset.
  - While the state is not `IDLE`, the counter increments every cycle.
  - When it reaches `TIMEOUT_CYCLES`: state -> `IDLE`, skip counter -> 0, `proto_err` pulses once, counter clears.
  - If a byte arrives in the same cycle, the byte takes precedence and the timeout is ignored.
- **Not defined:** no counter exists. Prefix and skip states persist until further bytes arrive.

## Structure
- **Package `ps2_pkg`:**
  - State enum `ps2_dec_state_t`.
  - Byte constants `PS2_EXT`=`E0`, `PS2_BRK`=`F0`, `PS2_PAUSE`=`E1`, `PS2_BAT_OK`=`AA`, `PS2_ACK`=`FA`, `PS2_ECHO`=`EE`, `PS2_RESEND`=`FE`, `PS2_BAT_FAIL`=`FC`, `PS2_OVR0`=`00`, `PS2_OVR1`=`FF`.
  - Packed struct `ps2_key_evt_t` {release, ext, code[7:0]}.
- **Sub-module `ps2_evt_fifo`:** parameterised FWFT FIFO of `ps2_key_evt_t`. The decode FSM stays in `ps2_key_ctrl`.

## Test plan
- **Plain make/break:** feed `1C`, `F0`, `1C` with `key_ready`=1 -> events {1C,0,0} then {1C,1,0}; `proto_err` never pulses.
- **Extended break:** feed `E0`, `F0`, `75` -> single event {75, release=1, ext=1}, visible one cycle after `75` is accepted.
- **Pause sequence:** feed `E1`, `14`, `77`, `E1`, `F0`, `14`, `F0`, `77`, `1C` -> exactly two events, {E1,0,0} and {1C,0,0}.
- **Overflow:** hold `key_ready`=0 and feed 9 codes with `FIFO_DEPTH`=8 -> 8 events retained, 1 `overflow` pulse. Then pop all 8 in order.
- **Errors and reset:**
  - Feed `F0`, `F0` -> one `proto_err` pulse.
  - Feed `FC` -> one `proto_err` pulse, no event.
  - Assert `rst_n`=0 after `E0` -> the next byte `1C` yields {1C,0,0}.
- **Timeout (with `PS2_PREFIX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100):**
  - Feed `E0`, idle 100 cycles -> one `proto_err` pulse; then `1C` yields {1C,0,0}.
  - Without the macro, the same stimulus yields {1C,0,1}.
